// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared direction-counter encodings, BTB entry layout and counter update helper
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int DEF_PC_W  = 9;
    localparam int DEF_IDX_W = 4;
    localparam int DEF_TAG_W = DEF_PC_W - DEF_IDX_W - 2;

    // Default-geometry entry view; btb_array re-declares the same layout at its own widths.
    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_PC_W-1:0]  target;
        logic [1:0]           cnt;
    } btb_entry_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/btb_array.sv
// rtl/btb_array.sv - direct-mapped BTB storage, one combinational lookup port and one resolve-update port
module btb_array
    import bp_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = PC_W - IDX_W - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [1:0]       rd_cnt,
    output logic [PC_W-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic             wr_is_jump,
    input  logic [PC_W-1:0]  wr_target
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       cnt;
    } entry_t;

    entry_t mem_q [ENTRIES];
    entry_t mem_d [ENTRIES];
    logic   wr_hit;

    // Lookup reads registered state only, so a same-cycle update is invisible until the next cycle.
    always_comb begin
        rd_hit    = mem_q[rd_idx].valid && (mem_q[rd_idx].tag == rd_tag);
        rd_cnt    = mem_q[rd_idx].cnt;
        rd_target = mem_q[rd_idx].target;
    end

    always_comb begin
        mem_d  = mem_q;
        wr_hit = mem_q[wr_idx].valid && (mem_q[wr_idx].tag == wr_tag);
        if (wr_en) begin
            if (wr_hit) begin
                mem_d[wr_idx].cnt = wr_is_jump ? ST : sat_update(mem_q[wr_idx].cnt, wr_taken);
                if (wr_taken) begin
                    mem_d[wr_idx].target = wr_target;
                end
            end else if (wr_taken) begin
                mem_d[wr_idx].valid  = 1'b1;
                mem_d[wr_idx].tag    = wr_tag;
                mem_d[wr_idx].target = wr_target;
                mem_d[wr_idx].cnt    = wr_is_jump ? ST : WT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_fetch_predictor.sv
// rtl/pc_fetch_predictor.sv - fetch PC register with BTB next-PC prediction, ID-stage redirect and perf counters
module pc_fetch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W        = 9,
    parameter int BTB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BTB_ENTRIES),
    parameter int TAG_W       = PC_W - IDX_W - 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             pred_taken_o,
    output logic [PC_W-1:0]  pred_target_o,
    input  logic             res_valid_i,
    input  logic             res_is_jump_i,
    input  logic [PC_W-1:0]  res_pc_i,
    input  logic             res_taken_i,
    input  logic [PC_W-1:0]  res_target_i,
    input  logic             res_pred_taken_i,
    input  logic [PC_W-1:0]  res_pred_target_i,
    output logic             flush_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
    logic             btb_hit;
    logic [1:0]       btb_cnt;
    logic [PC_W-1:0]  btb_target;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;

    btb_array #(
        .PC_W    (PC_W),
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (pc_q[IDX_W+1:2]),
        .rd_tag     (pc_q[PC_W-1:IDX_W+2]),
        .rd_hit     (btb_hit),
        .rd_cnt     (btb_cnt),
        .rd_target  (btb_target),
        .wr_en      (res_valid_i),
        .wr_idx     (res_pc_i[IDX_W+1:2]),
        .wr_tag     (res_pc_i[PC_W-1:IDX_W+2]),
        .wr_taken   (res_taken_i),
        .wr_is_jump (res_is_jump_i),
        .wr_target  (res_target_i)
    );

    always_comb begin
        pred_taken_o  = btb_hit && btb_cnt[1];
        pred_target_o = pred_taken_o ? btb_target : pc_q + PC_W'(4);

        // A taken branch with the right direction but a stale target is still a mispredict.
        mispredict  = !reset && res_valid_i &&
                      ((res_taken_i != res_pred_taken_i) ||
                       (res_taken_i && (res_target_i != res_pred_target_i)));
        redirect_pc = res_taken_i ? res_target_i : res_pc_i + PC_W'(4);

        if (mispredict) begin
            pc_d = redirect_pc;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else begin
            pc_d = pred_target_o;
        end

        br_cnt_d = br_cnt_q;
        if (res_valid_i && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        mp_cnt_d = mp_cnt_q;
        if (mispredict && (mp_cnt_q != '1)) begin
            mp_cnt_d = mp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            pc_q     <= pc_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign pc_o          = pc_q;
    assign flush_o       = mispredict;
    assign branch_cnt_o  = br_cnt_q;
    assign mispred_cnt_o = mp_cnt_q;

endmodule

// File: tb/tb_pc_fetch_predictor.sv
// tb/tb_pc_fetch_predictor.sv - directed scoreboard bench for pc_fetch_predictor
module tb_pc_fetch_predictor;

    localparam int PC_W  = 9;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall_i;
    logic [PC_W-1:0]  pc_o;
    logic             pred_taken_o;
    logic [PC_W-1:0]  pred_target_o;
    logic             res_valid_i;
    logic             res_is_jump_i;
    logic [PC_W-1:0]  res_pc_i;
    logic             res_taken_i;
    logic [PC_W-1:0]  res_target_i;
    logic             res_pred_taken_i;
    logic [PC_W-1:0]  res_pred_target_i;
    logic             flush_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    int vectors = 0;
    int errors  = 0;
    int exp_br  = 0;
    int exp_mp  = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    pc_fetch_predictor #(.PC_W(PC_W), .BTB_ENTRIES(16), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .pc_o              (pc_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .res_valid_i       (res_valid_i),
        .res_is_jump_i     (res_is_jump_i),
        .res_pc_i          (res_pc_i),
        .res_taken_i       (res_taken_i),
        .res_target_i      (res_target_i),
        .res_pred_taken_i  (res_pred_taken_i),
        .res_pred_target_i (res_pred_target_i),
        .flush_o           (flush_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispred_cnt_o     (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic expect_v(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_res();
        res_valid_i       = 1'b0;
        res_is_jump_i     = 1'b0;
        res_pc_i          = '0;
        res_taken_i       = 1'b0;
        res_target_i      = '0;
        res_pred_taken_i  = 1'b0;
        res_pred_target_i = '0;
    endtask

    task automatic check_pred(input string t, input logic taken, input logic [PC_W-1:0] target);
        expect_v({t, "_pred_taken"}, 32'(taken));
        expect_v({t, "_pred_target"}, 32'(target));
        check(32'(pred_taken_o));
        check(32'(pred_target_o));
    endtask

    task automatic check_cnts(input string t);
        expect_v({t, "_branch_cnt"}, 32'(exp_br));
        expect_v({t, "_mispred_cnt"}, 32'(exp_mp));
        check(32'(branch_cnt_o));
        check(32'(mispred_cnt_o));
    endtask

    task automatic resolve(input string t, input logic [PC_W-1:0] pc, input logic taken,
                           input logic jump, input logic [PC_W-1:0] target,
                           input logic ptaken, input logic [PC_W-1:0] ptarget,
                           input logic exp_flush, input logic [PC_W-1:0] exp_next);
        res_valid_i       = 1'b1;
        res_pc_i          = pc;
        res_taken_i       = taken;
        res_is_jump_i     = jump;
        res_target_i      = target;
        res_pred_taken_i  = ptaken;
        res_pred_target_i = ptarget;
        expect_v({t, "_flush"}, 32'(exp_flush));
        expect_v({t, "_next_pc"}, 32'(exp_next));
        exp_br = sat_inc(exp_br);
        if (exp_flush) exp_mp = sat_inc(exp_mp);
        #1;
        check(32'(flush_o));
        tick();
        clear_res();
        check(32'(pc_o));
    endtask

    // Not-taken resolve of p-4 that was predicted taken: redirects fetch to p without allocating.
    task automatic goto_pc(input logic [PC_W-1:0] p);
        resolve("goto", p - 9'h4, 1'b0, 1'b0, 9'h0, 1'b1, 9'h0, 1'b1, p);
    endtask

    initial begin
        reset   = 1'b1;
        stall_i = 1'b0;
        clear_res();
        #2;
        expect_v("rst_pc", 32'h0);        check(32'(pc_o));
        expect_v("rst_flush", 32'h0);     check(32'(flush_o));
        check_pred("rst", 1'b0, 9'h004);
        check_cnts("rst");
        res_valid_i = 1'b1; res_taken_i = 1'b1; res_target_i = 9'h040;
        #1;
        expect_v("rst_flush_gated", 32'h0); check(32'(flush_o));
        clear_res();
        tick();
        reset = 1'b0;
        expect_v("rel_pc", 32'h0); check(32'(pc_o));

        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_v("seq_pc", 32'(4 * i)); check(32'(pc_o));
        end
        repeat (124) tick();
        expect_v("pre_wrap_pc", 32'h1FC); check(32'(pc_o));
        tick();
        expect_v("wrap_pc", 32'h000); check(32'(pc_o));

        resolve("cold", 9'h010, 1'b1, 1'b0, 9'h040, 1'b0, 9'h014, 1'b1, 9'h040);
        check_cnts("cold");
        goto_pc(9'h010);
        check_pred("cold_fetch", 1'b1, 9'h040);

        resolve("hyst_t", 9'h010, 1'b1, 1'b0, 9'h040, 1'b1, 9'h040, 1'b0, 9'h040);
        resolve("hyst_nt1", 9'h010, 1'b0, 1'b0, 9'h000, 1'b1, 9'h040, 1'b1, 9'h014);
        goto_pc(9'h010);
        check_pred("hyst_wt", 1'b1, 9'h040);
        resolve("hyst_nt2", 9'h010, 1'b0, 1'b0, 9'h000, 1'b1, 9'h040, 1'b1, 9'h014);
        goto_pc(9'h010);
        check_pred("hyst_wnt", 1'b0, 9'h014);

        resolve("jalr_alloc", 9'h020, 1'b1, 1'b1, 9'h080, 1'b0, 9'h024, 1'b1, 9'h080);
        resolve("jalr_tgt", 9'h020, 1'b1, 1'b1, 9'h0C0, 1'b1, 9'h080, 1'b1, 9'h0C0);
        goto_pc(9'h020);
        check_pred("jalr_fetch", 1'b1, 9'h0C0);

        resolve("alias_jmp", 9'h010, 1'b1, 1'b1, 9'h040, 1'b0, 9'h014, 1'b1, 9'h040);
        goto_pc(9'h010);
        check_pred("alias_own", 1'b1, 9'h040);
        goto_pc(9'h050);
        check_pred("alias_miss", 1'b0, 9'h054);
        resolve("alias_evict", 9'h050, 1'b1, 1'b0, 9'h100, 1'b0, 9'h054, 1'b1, 9'h100);
        goto_pc(9'h010);
        check_pred("alias_evicted", 1'b0, 9'h014);
        goto_pc(9'h050);
        check_pred("alias_new", 1'b1, 9'h100);

        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_v("stall_pc", 32'h050); check(32'(pc_o));
        end
        check_pred("stall_btb", 1'b1, 9'h100);
        check_cnts("stall");
        resolve("stall_redirect", 9'h00C, 1'b0, 1'b0, 9'h000, 1'b1, 9'h000, 1'b1, 9'h010);
        stall_i = 1'b0;

        goto_pc(9'h050);
        stall_i           = 1'b1;
        res_valid_i       = 1'b1;
        res_pc_i          = 9'h050;
        res_taken_i       = 1'b0;
        res_pred_taken_i  = 1'b1;
        res_pred_target_i = 9'h100;
        expect_v("same_pred_taken", 32'h1);
        expect_v("same_pred_target", 32'h100);
        expect_v("same_flush", 32'h1);
        expect_v("same_next_pc", 32'h054);
        exp_br = sat_inc(exp_br);
        exp_mp = sat_inc(exp_mp);
        #1;
        check(32'(pred_taken_o));
        check(32'(pred_target_o));
        check(32'(flush_o));
        tick();
        clear_res();
        stall_i = 1'b0;
        check(32'(pc_o));
        goto_pc(9'h050);
        check_pred("same_after", 1'b0, 9'h054);
        check_cnts("sat");

        #1;
        reset = 1'b1;
        #1;
        expect_v("midrst_pc", 32'h0); check(32'(pc_o));
        exp_br = 0;
        exp_mp = 0;
        check_cnts("midrst");
        check_pred("midrst", 1'b0, 9'h004);
        tick();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
